capture_sequencer: RTL and testbench

//  Pixel-clock-domain controller for one still capture through the camera pipeline.

---
 rtl/camera_pkg.sv | 21 ++
 rtl/crop_window_calc.sv | 21 ++
 rtl/capture_sequencer.sv | 103 ++++++++++
 tb/tb_capture_sequencer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/camera_pkg.sv
// camera_pkg: shared capture sequencer types, sensor geometry and default crop windows
package camera_pkg;
  localparam logic [10:0] SENSOR_X_SIZE = 11'd1288;
  localparam logic [10:0] PAN_SIZE = 11'd720;
  localparam logic [10:0] PAN_Y_START = 11'd4;
  localparam logic [10:0] MIN_RES = 11'd16;
  typedef enum logic [2:0] {IDLE, ARM, WAIT_SOF, FRAME, WAIT_IMG} capture_state_t;
  typedef struct packed {
    logic [10:0] pan_x_start;
    logic [10:0] pan_x_end;
    logic [10:0] pan_y_start;
    logic [10:0] pan_y_end;
    logic [10:0] zoom_start;
    logic [10:0] zoom_end;
    logic [10:0] size;
  } window_t;
  localparam window_t DEF_WINDOW = '{
    pan_x_start: 11'd284, pan_x_end: 11'd1004, pan_y_start: 11'd4, pan_y_end: 11'd724,
    zoom_start: 11'd104, zoom_end: 11'd616, size: 11'd512
  };
endpackage

// File: rtl/crop_window_calc.sv
// crop_window_calc: clamps and aligns the requested pan/resolution and derives the crop windows
module crop_window_calc
  import camera_pkg::*;
(
  input  logic [10:0] x_pan,
  input  logic [10:0] resolution,
  output window_t     win
);
  localparam logic [10:0] MAX_PAN = SENSOR_X_SIZE - PAN_SIZE;
  logic [10:0] pan_c, res_c, pan, res, zoom;
  assign pan_c = x_pan > MAX_PAN ? MAX_PAN : x_pan;
  assign res_c = resolution < MIN_RES ? MIN_RES : resolution > PAN_SIZE ? PAN_SIZE : resolution;
  // even column keeps the Bayer phase; 16-pixel multiple keeps whole JPEG MCUs
  assign pan = pan_c & ~11'd1;
  assign res = res_c & 11'h7f0;
  assign zoom = (PAN_SIZE - res) >> 1;
  assign win = '{
    pan_x_start: pan, pan_x_end: pan + PAN_SIZE, pan_y_start: PAN_Y_START,
    pan_y_end: PAN_Y_START + PAN_SIZE, zoom_start: zoom, zoom_end: zoom + res, size: res
  };
endmodule

// File: rtl/capture_sequencer.sv
// capture_sequencer: sequences one still capture, applying crop windows only between frames
module capture_sequencer
  import camera_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2 ** 24
) (
  input  logic        pixel_clock_in,
  input  logic        pixel_reset_n_in,
  input  logic        start_capture_in,
  input  logic [10:0] x_pan_in,
  input  logic [10:0] resolution_in,
  input  logic        frame_valid_in,
  input  logic        image_valid_in,
  output logic [10:0] pan_x_start_out,
  output logic [10:0] pan_x_end_out,
  output logic [10:0] pan_y_start_out,
  output logic [10:0] pan_y_end_out,
  output logic [10:0] zoom_start_out,
  output logic [10:0] zoom_end_out,
  output logic [10:0] size_out,
  output logic        jpeg_start_out,
  output logic        busy_out,
  output logic        done_out,
  output logic        timeout_out
);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
  capture_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic start_q, fv_q, req, jpeg_n, done_n, timeout_n;
  logic [10:0] x_pan_q, x_pan_n, res_q, res_n;
  window_t win_q, win_n, calc;
  assign req = start_capture_in & ~start_q;
  crop_window_calc u_calc (.x_pan(x_pan_q), .resolution(res_q), .win(calc));
  // next state, config latch, window apply and pulses; timeout only when no edge-driven transition
  always_comb begin
    state_n = state;
    x_pan_n = x_pan_q;
    res_n = res_q;
    win_n = win_q;
    jpeg_n = 1'b0;
    done_n = 1'b0;
    timeout_n = 1'b0;
    case (state)
      IDLE: if (req) begin
        state_n = ARM;
        x_pan_n = x_pan_in;
        res_n = resolution_in;
      end
      ARM: if (!frame_valid_in) begin
        state_n = WAIT_SOF;
        win_n = calc;
        jpeg_n = 1'b1;
      end
      WAIT_SOF: if (frame_valid_in && !fv_q) state_n = FRAME;
      FRAME: if (!frame_valid_in && fv_q) state_n = WAIT_IMG;
      WAIT_IMG: if (image_valid_in) begin
        state_n = IDLE;
        done_n = 1'b1;
      end
      default: state_n = IDLE;
    endcase
    if (state != IDLE && state_n == state && cnt == LAST) begin
      state_n = IDLE;
      timeout_n = 1'b1;
    end
    cnt_n = (state_n != state || state == IDLE) ? '0 : cnt + 1'b1;
  end
  // state, counter, latched config and registered outputs
  always_ff @(posedge pixel_clock_in) begin
    if (!pixel_reset_n_in) begin
      state <= IDLE;
      cnt <= '0;
      start_q <= 1'b0;
      fv_q <= 1'b0;
      x_pan_q <= DEF_WINDOW.pan_x_start;
      res_q <= DEF_WINDOW.size;
      win_q <= DEF_WINDOW;
      jpeg_start_out <= 1'b0;
      done_out <= 1'b0;
      timeout_out <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      start_q <= start_capture_in;
      fv_q <= frame_valid_in;
      x_pan_q <= x_pan_n;
      res_q <= res_n;
      win_q <= win_n;
      jpeg_start_out <= jpeg_n;
      done_out <= done_n;
      timeout_out <= timeout_n;
    end
  end
  assign busy_out = state != IDLE;
  assign pan_x_start_out = win_q.pan_x_start;
  assign pan_x_end_out = win_q.pan_x_end;
  assign pan_y_start_out = win_q.pan_y_start;
  assign pan_y_end_out = win_q.pan_y_end;
  assign zoom_start_out = win_q.zoom_start;
  assign zoom_end_out = win_q.zoom_end;
  assign size_out = win_q.size;
endmodule

// File: tb/tb_capture_sequencer.sv
// tb_capture_sequencer: scoreboard bench for capture_sequencer windows, arming, done and timeout
module tb_capture_sequencer;
  typedef struct packed {
    logic [10:0] pxs, pxe, pys, pye, zs, ze, sz;
  } win_t;
  localparam win_t DEF = '{11'd284, 11'd1004, 11'd4, 11'd724, 11'd104, 11'd616, 11'd512};
  logic clk = 0, rst_n = 0, start = 0, fv = 0, iv = 0;
  logic [10:0] x_pan = 0, res = 0;
  logic [10:0] pxs, pxe, pys, pye, zs, ze, sz;
  logic jpeg, busy, done, tmo;
  int vectors = 0, miscompares = 0;
  int done_cnt = 0, to_cnt = 0, jpeg_cnt = 0;
  win_t sb[$];
  capture_sequencer #(.TIMEOUT_CYCLES(64)) dut (
    .pixel_clock_in(clk), .pixel_reset_n_in(rst_n), .start_capture_in(start),
    .x_pan_in(x_pan), .resolution_in(res), .frame_valid_in(fv), .image_valid_in(iv),
    .pan_x_start_out(pxs), .pan_x_end_out(pxe), .pan_y_start_out(pys), .pan_y_end_out(pye),
    .zoom_start_out(zs), .zoom_end_out(ze), .size_out(sz), .jpeg_start_out(jpeg),
    .busy_out(busy), .done_out(done), .timeout_out(tmo)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (tmo) to_cnt++;
    if (jpeg) jpeg_cnt++;
  end
  function automatic win_t model(input int x, input int r);
    int p, s;
    p = x > 568 ? 568 : x;
    p -= p % 2;
    s = r < 16 ? 16 : (r > 720 ? 720 : r);
    s -= s % 16;
    return '{11'(p), 11'(p + 720), 11'd4, 11'd724, 11'((720 - s) / 2), 11'((720 - s) / 2 + s), 11'(s)};
  endfunction
  function automatic win_t obs();
    return '{pxs, pxe, pys, pye, zs, ze, sz};
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst_n = 0; start = 0; fv = 0; iv = 0;
    tick(); tick();
    rst_n = 1;
    sb.delete();
  endtask
  task automatic request(input int x, input int r);
    x_pan = 11'(x); res = 11'(r);
    sb.push_back(model(x, r));
    start = 1;
    tick();
    start = 0;
  endtask
  task automatic wait_jpeg(input string name, input int bound, output int lat);
    win_t e;
    lat = 0;
    while (!jpeg && lat < bound) begin
      tick();
      lat++;
    end
    vectors++;
    if (!jpeg || sb.size() == 0) begin
      miscompares++;
      $display("FAIL %s arm: jpeg_start=%b after %0d cycles, queue=%0d, required pulse", name, jpeg, lat, sb.size());
    end else begin
      e = sb.pop_front();
      if (obs() !== e) begin
        miscompares++;
        $display("FAIL %s window: got %h required %h", name, obs(), e);
      end
    end
  endtask
  task automatic test_reset();
    rst_n = 0; x_pan = 11'd7; res = 11'd99; fv = 1;
    tick(); tick();
    vectors++;
    if (obs() !== DEF || {busy, jpeg, done, tmo} !== 4'b0) begin
      miscompares++;
      $display("FAIL reset: window %h flags %b required %h 0000", obs(), {busy, jpeg, done, tmo}, DEF);
    end
    rst_n = 1; fv = 0;
  endtask
  task automatic test_defaults();
    int lat;
    do_reset();
    request(284, 512);
    vectors++;
    if ({busy, jpeg} !== 2'b10) begin
      miscompares++;
      $display("FAIL defaults_req busy/jpeg: got %b required 10", {busy, jpeg});
    end
    wait_jpeg("defaults", 4, lat);
    vectors++;
    if (lat !== 1) begin
      miscompares++;
      $display("FAIL defaults_latency: got %0d required 1", lat);
    end
    tick();
    vectors++;
    if (jpeg !== 1'b0) begin
      miscompares++;
      $display("FAIL defaults_pulse_width: jpeg_start %b required 0", jpeg);
    end
  endtask
  task automatic test_clamp();
    int lat;
    int xs[4] = '{1000, 101, 0, 569};
    int rs[4] = '{1000, 37, 5, 721};
    for (int i = 0; i < 4; i++) begin
      do_reset();
      request(xs[i], rs[i]);
      wait_jpeg($sformatf("clamp%0d", i), 4, lat);
    end
  endtask
  task automatic test_mid_frame();
    int lat;
    do_reset();
    fv = 1;
    tick();
    request(101, 37);
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (obs() !== DEF || jpeg !== 1'b0) begin
        miscompares++;
        $display("FAIL mid_frame_hold%0d: window %h jpeg %b required %h 0", i, obs(), jpeg, DEF);
      end
      tick();
    end
    fv = 0;
    wait_jpeg("mid_frame", 4, lat);
    vectors++;
    if (lat !== 1) begin
      miscompares++;
      $display("FAIL mid_frame_latency: got %0d required 1", lat);
    end
  endtask
  task automatic test_full_flow();
    int lat, d0, t0, j0;
    do_reset();
    d0 = done_cnt; t0 = to_cnt; j0 = jpeg_cnt;
    request(300, 256);
    wait_jpeg("flow", 4, lat);
    tick();
    fv = 1;
    repeat (5) tick();
    x_pan = 11'd600; res = 11'd100; start = 1;
    tick();
    start = 0;
    repeat (25) tick();
    fv = 0;
    repeat (40) tick();
    vectors++;
    if ({busy, done} !== 2'b10) begin
      miscompares++;
      $display("FAIL flow_wait_img busy/done: got %b required 10", {busy, done});
    end
    iv = 1;
    tick();
    iv = 0;
    vectors++;
    if ({done, busy, tmo} !== 3'b100) begin
      miscompares++;
      $display("FAIL flow_done done/busy/timeout: got %b required 100", {done, busy, tmo});
    end
    tick();
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL flow_done_width: done %b required 0", done);
    end
    repeat (5) tick();
    vectors++;
    if (busy !== 1'b0 || jpeg_cnt - j0 != 1 || done_cnt - d0 != 1 || to_cnt != t0 || obs() !== model(300, 256)) begin
      miscompares++;
      $display("FAIL flow_ignored_req: busy %b jpeg %0d done %0d timeout %0d window %h required 0 1 1 0 %h",
               busy, jpeg_cnt - j0, done_cnt - d0, to_cnt - t0, obs(), model(300, 256));
    end
  endtask
  task automatic test_timeout();
    int lat, k, d0;
    do_reset();
    d0 = done_cnt;
    request(284, 512);
    wait_jpeg("timeout_arm", 4, lat);
    k = 0;
    while (!tmo && k < 100) begin
      tick();
      k++;
    end
    vectors++;
    if (k !== 64 || busy !== 1'b0 || done_cnt != d0) begin
      miscompares++;
      $display("FAIL timeout: after %0d cycles timeout %b busy %b done %0d required 64 1 0 0", k, tmo, busy, done_cnt - d0);
    end
    tick();
    vectors++;
    if (tmo !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_width: timeout %b required 0", tmo);
    end
  endtask
  task automatic test_reset_in_frame();
    int lat, d0, t0;
    do_reset();
    request(101, 37);
    wait_jpeg("rif_arm", 4, lat);
    tick();
    fv = 1;
    tick(); tick();
    d0 = done_cnt; t0 = to_cnt;
    rst_n = 0;
    tick();
    vectors++;
    if (obs() !== DEF || {busy, jpeg, done, tmo} !== 4'b0) begin
      miscompares++;
      $display("FAIL reset_in_frame: window %h flags %b required %h 0000", obs(), {busy, jpeg, done, tmo}, DEF);
    end
    rst_n = 1; fv = 0;
    repeat (3) tick();
    vectors++;
    if (done_cnt != d0 || to_cnt != t0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_in_frame_pulses: done %0d timeout %0d busy %b required 0 0 0", done_cnt - d0, to_cnt - t0, busy);
    end
  endtask
  initial begin
    test_reset();
    test_defaults();
    test_clamp();
    test_mid_frame();
    test_full_flow();
    test_timeout();
    test_reset_in_frame();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
